// File: rtl/dispatched_fifos.sv
// One-to-N dispatcher: a single producer stream is steered by a one-hot tag
// into per-destination FIFOs that drain independently; rejected pushes are counted.
module dispatched_fifos #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CWID     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [NUM_REQS-1:0]       dest,
  input  logic [WIDTH-1:0]          data_in,
  input  logic [NUM_REQS-1:0]       pop,
  output logic                      accepted,
  output logic [NUM_REQS-1:0]       empty,
  output logic [NUM_REQS-1:0]       full,
  output logic [NUM_REQS*WIDTH-1:0] flat_data_out,
  output logic [CWID-1:0]           drop_cnt
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem_q  [NUM_REQS][DEPTH];
  logic [PW-1:0]       wptr_q [NUM_REQS];
  logic [PW-1:0]       wptr_d [NUM_REQS];
  logic [PW-1:0]       rptr_q [NUM_REQS];
  logic [PW-1:0]       rptr_d [NUM_REQS];
  logic [CNTW-1:0]     cnt_q  [NUM_REQS];
  logic [CNTW-1:0]     cnt_d  [NUM_REQS];
  logic [CWID-1:0]     drop_q;
  logic [CWID-1:0]     drop_d;
  logic [NUM_REQS-1:0] dest_m1;
  logic                dest_ok;
  logic [NUM_REQS-1:0] wr;
  logic [NUM_REQS-1:0] rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [CWID-1:0] sat_inc(input logic [CWID-1:0] v);
    return (v == {CWID{1'b1}}) ? v : v + CWID'(1);
  endfunction

  assign dest_m1  = dest - NUM_REQS'(1);
  assign dest_ok  = (dest != '0) && ((dest & dest_m1) == '0);
  // Uses registered full only, so pop never reaches accepted combinationally.
  assign accepted = push & dest_ok & ~|(dest & full);
  assign drop_cnt = drop_q;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      empty[i] = (cnt_q[i] == '0);
      full[i]  = (cnt_q[i] == CNTW'(DEPTH));
      wr[i]    = accepted & dest[i];
      rd[i]    = pop[i] & ~empty[i];
    end
  end

  always_comb begin
    flat_data_out = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!empty[i]) flat_data_out[i*WIDTH +: WIDTH] = mem_q[i][rptr_q[i]];
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (push && !accepted) drop_d = sat_inc(drop_q);
    for (int i = 0; i < NUM_REQS; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (wr[i]) wptr_d[i] = next_ptr(wptr_q[i]);
      if (rd[i]) rptr_d[i] = next_ptr(rptr_q[i]);
      unique case ({wr[i], rd[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNTW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNTW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      drop_q <= drop_d;
      for (int i = 0; i < NUM_REQS; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Storage carries no reset; the head is masked to zero while a lane is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!rst && wr[i]) mem_q[i][wptr_q[i]] <= data_in;
    end
  end

endmodule

// File: tb/tb_dispatched_fifos.sv
// Directed and scoreboard-driven bench for dispatched_fifos (4 lanes, 8-bit, depth 4).
module tb_dispatched_fifos;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [3:0]  dest = '0;
  logic [7:0]  data_in = '0;
  logic [3:0]  pop = '0;
  logic        accepted;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic [31:0] flat_data_out;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  dispatched_fifos #(.NUM_REQS(4), .WIDTH(8), .DEPTH(4), .CWID(8)) dut (
    .clk(clk), .rst(rst), .push(push), .dest(dest), .data_in(data_in),
    .pop(pop), .accepted(accepted), .empty(empty), .full(full),
    .flat_data_out(flat_data_out), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] head(input int i);
    return flat_data_out[i*8 +: 8];
  endfunction

  logic [7:0] q [4][$];
  logic [7:0] lanes [3];

  initial begin
    lanes[0] = 8'd0; lanes[1] = 8'd1; lanes[2] = 8'd3;

    // Reset then idle
    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_flat", flat_data_out, 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_acc", 32'(accepted), 32'h0);

    // Three words through lane 2
    for (int k = 0; k < 3; k++) begin
      push = 1'b1; dest = 4'b0100; data_in = 8'(8'h11 * (k + 1));
      #1 chk("l2_acc", 32'(accepted), 32'h1);
      tick;
    end
    push = 1'b0; dest = '0;
    #1;
    chk("l2_empty", 32'(empty), 32'hB);
    chk("l2_head0", 32'(head(2)), 32'h11);
    chk("l2_others", flat_data_out & 32'hFF00FFFF, 32'h0);
    pop = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      chk("l2_pophead", 32'(head(2)), 32'(8'h11 * (k + 1)));
      tick;
    end
    pop = '0;
    #1;
    chk("l2_drained", 32'(empty), 32'hF);
    chk("l2_zero", flat_data_out, 32'h0);

    // Overfill lane 0
    for (int k = 0; k < 5; k++) begin
      push = 1'b1; dest = 4'b0001; data_in = 8'(8'hA0 + k);
      #1 chk("l0_acc", 32'(accepted), (k < 4) ? 32'h1 : 32'h0);
      tick;
      if (k == 3) chk("l0_full", 32'(full), 32'h1);
    end
    push = 1'b0; dest = '0;
    #1;
    chk("l0_drop", 32'(drop_cnt), 32'h1);
    pop = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      chk("l0_head", 32'(head(0)), 32'(8'hA0 + k));
      tick;
    end
    pop = '0;
    #1 chk("l0_empty", 32'(empty), 32'hF);

    // Lane 3 full with simultaneous push and pop
    for (int k = 0; k < 4; k++) begin
      push = 1'b1; dest = 4'b1000; data_in = 8'(8'hB0 + k);
      tick;
    end
    #1 chk("l3_full", 32'(full), 32'h8);
    push = 1'b1; dest = 4'b1000; data_in = 8'hC0; pop = 4'b1000;
    #1 chk("l3_fullpush_acc", 32'(accepted), 32'h0);
    tick;
    push = 1'b0; pop = '0;
    #1;
    chk("l3_drop", 32'(drop_cnt), 32'h2);
    chk("l3_notfull", 32'(full), 32'h0);
    pop = 4'b1000;
    for (int k = 1; k < 4; k++) begin
      chk("l3_head", 32'(head(3)), 32'(8'hB0 + k));
      tick;
    end
    pop = '0;
    #1 chk("l3_cnt3_empty", 32'(empty), 32'hF);
    push = 1'b1; dest = 4'b1000; data_in = 8'hD0; pop = 4'b1000;
    #1 chk("l3_emptypush_acc", 32'(accepted), 32'h1);
    tick;
    push = 1'b0; pop = '0;
    #1;
    chk("l3_nonempty", 32'(empty), 32'h7);
    chk("l3_d0", 32'(head(3)), 32'hD0);
    pop = 4'b1000;
    tick;
    pop = '0;
    #1 chk("l3_cnt1", 32'(empty), 32'hF);

    // Invalid destinations and saturation
    push = 1'b1; dest = 4'b0000; data_in = 8'h55;
    #1 chk("inv0_acc", 32'(accepted), 32'h0);
    tick;
    dest = 4'b0110;
    #1 chk("inv6_acc", 32'(accepted), 32'h0);
    tick;
    push = 1'b0; dest = '0;
    #1;
    chk("inv_drop", 32'(drop_cnt), 32'h4);
    chk("inv_empty", 32'(empty), 32'hF);
    push = 1'b1; dest = 4'b0011;
    for (int k = 0; k < 300; k++) tick;
    push = 1'b0; dest = '0;
    #1 chk("drop_sat", 32'(drop_cnt), 32'hFF);

    // Reset mid-stream with lane 1 holding 3 words
    for (int k = 0; k < 3; k++) begin
      push = 1'b1; dest = 4'b0010; data_in = 8'(8'hE0 + k);
      tick;
    end
    push = 1'b0; dest = '0;
    #1 chk("l1_loaded", 32'(empty), 32'hD);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("midrst_empty", 32'(empty), 32'hF);
    chk("midrst_flat", flat_data_out, 32'h0);
    chk("midrst_drop", 32'(drop_cnt), 32'h0);

    // Randomized traffic against per-lane queues
    for (int c = 0; c < 1000; c++) begin
      logic       p;
      logic [3:0] pp;
      int         d;
      logic       exp_acc;
      int         sz [4];
      for (int i = 0; i < 4; i++) begin
        sz[i] = q[i].size();
        chk("rnd_empty", 32'(empty[i]), 32'(sz[i] == 0));
        chk("rnd_full", 32'(full[i]), 32'(sz[i] == 4));
        chk("rnd_head", 32'(head(i)), (sz[i] == 0) ? 32'h0 : 32'(q[i][0]));
      end
      p  = 1'($urandom_range(0, 3) != 0);
      d  = int'(lanes[$urandom_range(0, 2)]);
      pp = 4'($urandom);
      push = p; dest = 4'(1 << d); data_in = 8'($urandom); pop = pp;
      exp_acc = p && (sz[d] < 4);
      #1 chk("rnd_acc", 32'(accepted), 32'(exp_acc));
      for (int i = 0; i < 4; i++)
        if (pp[i] && sz[i] > 0) void'(q[i].pop_front());
      if (exp_acc) q[d].push_back(data_in);
      tick;
    end
    push = 1'b0; pop = '0; dest = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
